// File: rtl/hub75_row_readout_pkg.sv
// Shared geometry, framebuffer address packing and pixel-to-plane conversion
// for the HUB75 row read-out path.
package hub75_row_readout_pkg;

  localparam int N_BANKS  = 2;
  localparam int N_ROWS   = 32;
  localparam int N_COLS   = 64;
  localparam int N_CHANS  = 3;
  localparam int N_PLANES = 8;
  localparam int BITDEPTH = 24;
  localparam int FB_AW    = 13;
  localparam int FB_DW    = 16;
  localparam int FB_DC    = 2;

  localparam int LOG_N_ROWS  = $clog2(N_ROWS);
  localparam int LOG_N_COLS  = $clog2(N_COLS);
  localparam int LOG_N_BANKS = $clog2(N_BANKS);
  localparam int LOG_FB_DC   = $clog2(FB_DC);

  localparam int CW       = BITDEPTH / N_CHANS;
  localparam int LANE_W   = N_CHANS * N_PLANES;
  localparam int RD_W     = N_BANKS * LANE_W;
  localparam int CNT_W    = LOG_N_BANKS + LOG_N_COLS + LOG_FB_DC;
  localparam int PIX_W    = FB_DC * FB_DW;
  localparam int LB_AW    = 1 + LOG_N_COLS;
  localparam int LB_DEPTH = 2 * N_COLS;

  // Wide channels keep their MSBs; narrow ones are left-aligned with zero LSBs.
  localparam int SH_R = (CW >= N_PLANES) ? (CW - N_PLANES) : 0;
  localparam int SH_L = (CW >= N_PLANES) ? 0 : (N_PLANES - CW);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_READ = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  function automatic logic [FB_AW-1:0] fb_pack(
    input logic [LOG_N_BANKS-1:0] bank,
    input logic [LOG_N_ROWS-1:0]  row,
    input logic [LOG_N_COLS-1:0]  col,
    input logic [LOG_FB_DC-1:0]   dc
  );
    return {bank, row, col, dc};
  endfunction

  // The fetch counter is laid out {bank, col, dc} so a plain increment walks the row.
  function automatic logic [FB_AW-1:0] cnt_to_addr(
    input logic [LOG_N_ROWS-1:0] row,
    input logic [CNT_W-1:0]      cnt
  );
    return fb_pack(cnt[CNT_W-1 -: LOG_N_BANKS], row,
                   cnt[LOG_FB_DC +: LOG_N_COLS], cnt[LOG_FB_DC-1:0]);
  endfunction

  function automatic logic [LANE_W-1:0] pixel_to_planes(input logic [BITDEPTH-1:0] pixel);
    logic [CW-1:0]     ch;
    logic [LANE_W-1:0] lane;
    lane = '0;
    for (int c = 0; c < N_CHANS; c++) begin
      ch = pixel[c*CW +: CW];
      lane[c*N_PLANES +: N_PLANES] = N_PLANES'(ch >> SH_R) << SH_L;
    end
    return lane;
  endfunction

endpackage

// File: rtl/hub75_row_linebuf.sv
// Double line buffer: one lane per bank, address MSB selects front/back half.
module hub75_row_linebuf
  import hub75_row_readout_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_BANKS-1:0] we_i,
  input  logic [LB_AW-1:0]   waddr_i,
  input  logic [LANE_W-1:0]  wdata_i,
  input  logic               re_i,
  input  logic [LB_AW-1:0]   raddr_i,
  output logic [RD_W-1:0]    rdata_o
);

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic [LANE_W-1:0] mem_q [LB_DEPTH];
    logic [LANE_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
      if (we_i[b]) mem_q[waddr_i] <= wdata_i;
    end

    // Only the read register is cleared; the array keeps stale contents.
    always_ff @(posedge clk_i) begin
      if (rst_i)     rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o[b*LANE_W +: LANE_W] = rdata_q;
  end

endmodule

// File: rtl/hub75_row_readout.sv
// HUB75 row read-out: fetches one row per request from the shared framebuffer
// and lands it, split into bit-planes, in the back half of a double line buffer.
module hub75_row_readout
  import hub75_row_readout_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LOG_N_ROWS-1:0] rd_row_addr,
  input  logic                  rd_row_load,
  output logic                  rd_row_rdy,
  input  logic                  rd_row_swap,
  output logic [RD_W-1:0]       rd_data,
  input  logic [LOG_N_COLS-1:0] rd_col_addr,
  input  logic                  rd_en,
  output logic                  ctrl_req,
  input  logic                  ctrl_gnt,
  output logic                  ctrl_rel,
  output logic [FB_AW-1:0]      fb_addr,
  input  logic [FB_DW-1:0]      fb_data
);

  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(N_BANKS * N_COLS * FB_DC - 1);
  localparam logic [LOG_FB_DC-1:0] DC_LAST  = LOG_FB_DC'(FB_DC - 1);

  state_t                state_q, state_d;
  logic [LOG_N_ROWS-1:0] row_q, row_d;
  logic                  wbuf_q, wbuf_d;
  logic                  front_q;
  logic                  issue_q, issue_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [FB_AW-1:0]      fb_addr_q, fb_addr_d;

  logic                   cap_v_q;
  logic [CNT_W-1:0]       cap_cnt_q;
  logic [PIX_W-1:0]       pix_acc_q, pix_full;
  logic [LOG_N_BANKS-1:0] cap_bank;
  logic [LOG_N_COLS-1:0]  cap_col;
  logic [LOG_FB_DC-1:0]   cap_dc;
  logic                   last_word, last_write;
  logic [N_BANKS-1:0]     lb_we;
  logic [LANE_W-1:0]      lb_wdata;
  logic                   unused_pix;

  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign cap_bank   = cap_cnt_q[CNT_W-1 -: LOG_N_BANKS];
  assign cap_col    = cap_cnt_q[LOG_FB_DC +: LOG_N_COLS];
  assign cap_dc     = cap_cnt_q[LOG_FB_DC-1:0];
  assign last_word  = cap_v_q && (cap_dc == DC_LAST);
  assign last_write = last_word && (cap_cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    wbuf_d    = wbuf_q;
    issue_d   = issue_q;
    cnt_d     = cnt_q;
    fb_addr_d = fb_addr_q;
    case (state_q)
      ST_IDLE: begin
        // A swap in the same cycle takes effect first, so target the new back half.
        if (rd_row_load) begin
          row_d   = rd_row_addr;
          wbuf_d  = ~(front_q ^ rd_row_swap);
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ctrl_gnt) begin
          state_d   = ST_READ;
          issue_d   = 1'b1;
          cnt_d     = '0;
          fb_addr_d = cnt_to_addr(row_q, '0);
        end
      end
      ST_READ: begin
        if (issue_q) begin
          if (cnt_q == CNT_LAST) begin
            issue_d = 1'b0;
          end else begin
            cnt_d     = cnt_inc;
            fb_addr_d = cnt_to_addr(row_q, cnt_inc);
          end
        end
        if (last_write) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      wbuf_q    <= 1'b0;
      front_q   <= 1'b0;
      issue_q   <= 1'b0;
      cnt_q     <= '0;
      fb_addr_q <= '0;
      cap_v_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      wbuf_q    <= wbuf_d;
      front_q   <= front_q ^ rd_row_swap;
      issue_q   <= issue_d;
      cnt_q     <= cnt_d;
      fb_addr_q <= fb_addr_d;
      cap_v_q   <= (state_q == ST_READ) && issue_q;
    end
  end

  // fb_data belongs to the address issued one cycle earlier, tracked by cap_cnt_q.
  always_ff @(posedge clk) begin
    cap_cnt_q <= cnt_q;
    if (cap_v_q) pix_acc_q[cap_dc*FB_DW +: FB_DW] <= fb_data;
  end

  always_comb begin
    pix_full = pix_acc_q;
    pix_full[PIX_W-1 -: FB_DW] = fb_data;
  end

  assign unused_pix = ^pix_full[PIX_W-1:BITDEPTH];
  assign lb_wdata   = pixel_to_planes(pix_full[BITDEPTH-1:0]);
  assign lb_we      = last_word ? (N_BANKS'(1) << cap_bank) : '0;

  hub75_row_linebuf u_linebuf (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (lb_we),
    .waddr_i ({wbuf_q, cap_col}),
    .wdata_i (lb_wdata),
    .re_i    (rd_en),
    .raddr_i ({front_q, rd_col_addr}),
    .rdata_o (rd_data)
  );

  assign rd_row_rdy = (state_q == ST_IDLE);
  assign ctrl_req   = (state_q == ST_REQ);
  assign ctrl_rel   = (state_q == ST_DONE);
  assign fb_addr    = fb_addr_q;

endmodule

// File: tb/tb_hub75_row_readout.sv
// Directed bench for hub75_row_readout with a behavioural framebuffer that
// answers each word address one cycle later.
module tb_hub75_row_readout;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_row_addr;
  logic        rd_row_load;
  logic        rd_row_rdy;
  logic        rd_row_swap;
  logic [47:0] rd_data;
  logic [5:0]  rd_col_addr;
  logic        rd_en;
  logic        ctrl_req;
  logic        ctrl_gnt;
  logic        ctrl_rel;
  logic [12:0] fb_addr;
  logic [15:0] fb_data;

  int errCount   = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  hub75_row_readout dut (
    .clk         (clk),
    .rst         (rst),
    .rd_row_addr (rd_row_addr),
    .rd_row_load (rd_row_load),
    .rd_row_rdy  (rd_row_rdy),
    .rd_row_swap (rd_row_swap),
    .rd_data     (rd_data),
    .rd_col_addr (rd_col_addr),
    .rd_en       (rd_en),
    .ctrl_req    (ctrl_req),
    .ctrl_gnt    (ctrl_gnt),
    .ctrl_rel    (ctrl_rel),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data)
  );

  // Pixel held in the framebuffer; bank0/row3/col5 is the hand-computed vector.
  function automatic logic [23:0] pixOf(input int bank, input int row, input int col);
    if (bank == 0 && row == 3 && col == 5) return 24'h123456;
    return {8'(bank * 64 + row), 8'(col * 3 + 1), 8'(255 - col - bank)};
  endfunction

  // Word address layout {bank[12], row[11:7], col[6:1], dc[0]}; upper byte of word 1 is junk.
  function automatic logic [15:0] fbWord(input logic [12:0] a);
    logic [23:0] p;
    int bank, row, col;
    bank = int'(a[12]);
    row  = int'(a[11:7]);
    col  = int'(a[6:1]);
    p    = pixOf(bank, row, col);
    if (a[0] == 1'b0) return p[15:0];
    return {((bank == 0 && row == 3 && col == 5) ? 8'h00 : 8'hC3), p[23:16]};
  endfunction

  function automatic logic [12:0] expAddr(input int row, input int i);
    return 13'(((i / 128) << 12) | (row << 7) | (((i / 2) % 64) << 1) | (i % 2));
  endfunction

  function automatic logic [47:0] expLine(input int row, input int col);
    return {pixOf(1, row, col), pixOf(0, row, col)};
  endfunction

  always @(posedge clk) fb_data <= fbWord(fb_addr);

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Pulse rd_row_load for one cycle, optionally together with a swap.
  task automatic applyStimulus(input int row, input logic withSwap);
    rd_row_addr = 5'(row);
    rd_row_load = 1'b1;
    rd_row_swap = withSwap;
    tick();
    rd_row_load = 1'b0;
    rd_row_swap = 1'b0;
  endtask

  // Arbitration, full address sequence, release pulse; a busy load of row 7 is injected.
  task automatic runLoad(input int row, input int gntDelay);
    checkOutput("reqAfterLoad", 64'(ctrl_req), 64'd1);
    checkOutput("rdyBusy", 64'(rd_row_rdy), 64'd0);
    for (int i = 0; i < gntDelay; i++) begin
      checkOutput("reqHold", 64'(ctrl_req), 64'd1);
      checkOutput("addrIdleBeforeGnt", 64'(fb_addr), 64'd0);
      tick();
    end
    ctrl_gnt = 1'b1;
    tick();
    ctrl_gnt = 1'b0;
    checkOutput("reqAfterGnt", 64'(ctrl_req), 64'd0);
    for (int i = 0; i < 256; i++) begin
      checkOutput("fbAddr", 64'(fb_addr), 64'(expAddr(row, i)));
      if (i == 20) begin
        rd_row_addr = 5'd7;
        rd_row_load = 1'b1;
      end
      if (i == 21) rd_row_load = 1'b0;
      if (i == 128) checkOutput("relMidRead", 64'(ctrl_rel), 64'd0);
      tick();
    end
    checkOutput("addrAfterLast", 64'(fb_addr), 64'(expAddr(row, 255)));
    checkOutput("relEarly", 64'(ctrl_rel), 64'd0);
    tick();
    checkOutput("relPulse", 64'(ctrl_rel), 64'd1);
    checkOutput("rdyDuringRel", 64'(rd_row_rdy), 64'd0);
    tick();
    checkOutput("relDrop", 64'(ctrl_rel), 64'd0);
    checkOutput("rdyAfterRel", 64'(rd_row_rdy), 64'd1);
  endtask

  task automatic readCol(input string tag, input int col, input logic [47:0] exp);
    rd_en       = 1'b1;
    rd_col_addr = 6'(col);
    tick();
    rd_en = 1'b0;
    checkOutput(tag, 64'(rd_data), 64'(exp));
  endtask

  initial begin
    rst         = 1'b1;
    rd_row_addr = '0;
    rd_row_load = 1'b0;
    rd_row_swap = 1'b0;
    rd_col_addr = '0;
    rd_en       = 1'b0;
    ctrl_gnt    = 1'b0;
    tick();
    tick();
    checkOutput("resetRdy", 64'(rd_row_rdy), 64'd1);
    checkOutput("resetReq", 64'(ctrl_req), 64'd0);
    checkOutput("resetRel", 64'(ctrl_rel), 64'd0);
    checkOutput("resetAddr", 64'(fb_addr), 64'd0);
    checkOutput("resetData", 64'(rd_data), 64'd0);
    rst = 1'b0;
    tick();
    checkOutput("idleRdy", 64'(rd_row_rdy), 64'd1);

    $display("[TB] load row 3 with a 10-cycle grant delay");
    applyStimulus(3, 1'b0);
    runLoad(3, 10);
    rd_row_swap = 1'b1;
    tick();
    rd_row_swap = 1'b0;
    readCol("row3col5", 5, expLine(3, 5));
    checkOutput("col5chan0", 64'(rd_data[7:0]), 64'h56);
    checkOutput("col5chan1", 64'(rd_data[15:8]), 64'h34);
    checkOutput("col5chan2", 64'(rd_data[23:16]), 64'h12);
    readCol("row3col0", 0, expLine(3, 0));
    readCol("row3col63", 63, expLine(3, 63));
    rd_col_addr = 6'd1;
    tick();
    checkOutput("dataHold", 64'(rd_data), 64'(expLine(3, 63)));

    $display("[TB] reset in the middle of a row fetch");
    applyStimulus(9, 1'b0);
    ctrl_gnt = 1'b1;
    tick();
    ctrl_gnt = 1'b0;
    repeat (30) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abortRdy", 64'(rd_row_rdy), 64'd1);
    checkOutput("abortReq", 64'(ctrl_req), 64'd0);
    checkOutput("abortRel", 64'(ctrl_rel), 64'd0);
    checkOutput("abortAddr", 64'(fb_addr), 64'd0);
    checkOutput("abortData", 64'(rd_data), 64'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("noRelAfterAbort", 64'(ctrl_rel), 64'd0);
      tick();
    end

    $display("[TB] load row 31 with a simultaneous swap");
    applyStimulus(31, 1'b1);
    runLoad(31, 2);
    readCol("staleFrontCol5", 5, expLine(3, 5));
    rd_row_swap = 1'b1;
    tick();
    rd_row_swap = 1'b0;
    readCol("row31col63", 63, expLine(31, 63));
    readCol("row31col5", 5, expLine(31, 5));

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
